// File: rtl/memory_load_sequencer_if.sv
// Shared word-format definitions, plus the handshake bundle between the
// upstream word source, the load sequencer and the memory engine.
package data_type_pkg;
    localparam int INT_WIDTH  = 8;
    localparam int FRAC_WIDTH = 8;
endpackage

interface memory_load_sequencer_if;
    import data_type_pkg::*;

    localparam int W = INT_WIDTH + FRAC_WIDTH;

    // Upstream word stream
    logic         in_val;
    logic         in_rdy;
    logic [W-1:0] in_data;
    logic         in_last;

    // Message stream toward the memory engine: {data, cmd}
    logic         send_val;
    logic         send_rdy;
    logic [W+1:0] send_msg;

    // Sequencer side
    modport slave (
        input  in_val, in_data, in_last, send_rdy,
        output in_rdy, send_val, send_msg
    );

    // Environment side (word source and memory engine)
    modport master (
        output in_val, in_data, in_last, send_rdy,
        input  in_rdy, send_val, send_msg
    );
endinterface

// File: rtl/memory_load_sequencer.sv
// Memory load sequencer: forwards upstream words as write messages, pads
// short frames with zero writes up to DATA_ENTRIES, then issues one run
// message per frame and counts the run messages issued.
module memory_load_sequencer #(
    parameter int DATA_ENTRIES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    memory_load_sequencer_if.slave  bus,
    output logic [7:0]              frame_cnt,
    output logic                    busy
);
    import data_type_pkg::*;

    localparam int W     = INT_WIDTH + FRAC_WIDTH;
    localparam int CNT_W = $clog2(DATA_ENTRIES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_ENTRIES - 1);

    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b11;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        PAD  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    // State, entry counter and frame counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it only takes effect on a rising edge.
        if (reset) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic and handshake/message outputs for the current state.
    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no
        // path through the case statement can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_cnt_d  = frame_cnt_q;
        bus.in_rdy   = 1'b0;
        bus.send_val = 1'b0;
        bus.send_msg = '0;

        unique case (state_q)
            LOAD: begin
                // Zero-latency pass-through of the upstream word.
                bus.send_val = bus.in_val;
                bus.in_rdy   = bus.send_rdy;
                if (bus.in_val) begin
                    bus.send_msg = {bus.in_data, CMD_WRITE};
                end
                if (bus.in_val && bus.send_rdy) begin
                    if (cnt_q == LAST_IDX) begin
                        // A full frame ends here whether or not in_last is set.
                        state_d = RUN;
                        cnt_d   = '0;
                    end else if (bus.in_last) begin
                        state_d = PAD;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end

            PAD: begin
                bus.send_val = 1'b1;
                bus.send_msg = {{W{1'b0}}, CMD_WRITE};
                if (bus.send_rdy) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end

            RUN: begin
                bus.send_val = 1'b1;
                bus.send_msg = {{W{1'b0}}, CMD_RUN};
                if (bus.send_rdy) begin
                    state_d     = LOAD;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        endcase

        // No handshake is offered in either direction while reset is held.
        if (reset) begin
            bus.in_rdy   = 1'b0;
            bus.send_val = 1'b0;
            bus.send_msg = '0;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != LOAD) || (cnt_q != '0);

endmodule

// File: tb/tb_memory_load_sequencer.sv
// Directed bench for memory_load_sequencer with DATA_ENTRIES = 4. Expected
// messages go into a queue as stimulus is planned; a monitor pops and
// compares one entry on every downstream transfer.
module tb_memory_load_sequencer;
    import data_type_pkg::*;

    localparam int DE = 4;
    localparam int W  = INT_WIDTH + FRAC_WIDTH;
    localparam logic [W+1:0] RUN_MSG = {{W{1'b0}}, 2'b11};
    localparam logic [W+1:0] PAD_MSG = {{W{1'b0}}, 2'b00};

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] frame_cnt;
    logic       busy;

    memory_load_sequencer_if bus();

    memory_load_sequencer #(.DATA_ENTRIES(DE)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    logic [W+1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every downstream transfer must match the oldest expectation.
    always @(posedge clk) begin
        if (bus.send_val === 1'b1 && bus.send_rdy === 1'b1) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("send_msg", 32'(bus.send_msg), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic exp_write(input logic [W-1:0] d);
        exp_q.push_back({d, 2'b00});
    endtask

    // Offer one word; returns just after the edge on which it was accepted.
    task automatic send_word(input logic [W-1:0] d, input bit last);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            bus.in_val  = 1'b1;
            bus.in_data = d;
            bus.in_last = last;
            #1;
            if (bus.in_rdy === 1'b1) begin
                check("passthru_val", 32'(bus.send_val), 32'd1);
                check("passthru_msg", 32'(bus.send_msg), 32'({d, 2'b00}));
                done = 1'b1;
                @(posedge clk);
            end
        end
        check("in_rdy_timeout", 32'(done), 32'd1);
        #1;
        bus.in_val  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    // Random full frame; optionally flags the final word with in_last.
    task automatic full_frame(input bit mark_last);
        logic [W-1:0] d[DE];
        for (int i = 0; i < DE; i++) begin
            d[i] = W'($urandom);
            exp_write(d[i]);
        end
        exp_q.push_back(RUN_MSG);
        for (int i = 0; i < DE; i++) begin
            send_word(d[i], mark_last && (i == DE - 1));
        end
    endtask

    // Wait (bounded) until every expected message has been delivered.
    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_val   = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.send_rdy = 1'b1;

        // Reset: no handshake even with a word offered and the engine ready.
        @(negedge clk);
        bus.in_val  = 1'b1;
        bus.in_data = W'(16'h0abc);
        #1;
        check("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("rst_send_val", 32'(bus.send_val), 32'd0);
        check("rst_send_msg", 32'(bus.send_msg), 32'd0);
        @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        bus.in_val = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        #1;
        check("idle_send_msg", 32'(bus.send_msg), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Full frame 1,2,3,4 then run.
        for (int i = 1; i <= DE; i++) exp_write(W'(i));
        exp_q.push_back(RUN_MSG);
        send_word(W'(1), 1'b0);
        check("partial_busy", 32'(busy), 32'd1);
        send_word(W'(2), 1'b0);
        send_word(W'(3), 1'b0);
        send_word(W'(4), 1'b0);
        check("run_val", 32'(bus.send_val), 32'd1);
        check("run_msg", 32'(bus.send_msg), 32'(RUN_MSG));
        check("run_in_rdy", 32'(bus.in_rdy), 32'd0);
        @(posedge clk);
        #1;
        check("full_frame_cnt", 32'(frame_cnt), 32'd1);
        check("full_busy", 32'(busy), 32'd0);

        // Short frame 7,8(last): pads 0,0 then run; upstream blocked 3 cycles.
        exp_write(W'(7));
        exp_write(W'(8));
        exp_q.push_back(PAD_MSG);
        exp_q.push_back(PAD_MSG);
        exp_q.push_back(RUN_MSG);
        send_word(W'(7), 1'b0);
        send_word(W'(8), 1'b1);
        bus.in_val  = 1'b1;
        bus.in_data = W'(9);
        for (int k = 0; k < 3; k++) begin
            check("short_in_rdy", 32'(bus.in_rdy), 32'd0);
            check("short_send_val", 32'(bus.send_val), 32'd1);
            @(posedge clk);
            #1;
        end
        check("short_back_in_rdy", 32'(bus.in_rdy), 32'd1);
        bus.in_val = 1'b0;
        check("short_frame_cnt", 32'(frame_cnt), 32'd2);
        check("short_queue", 32'(exp_q.size()), 32'd0);

        // Backpressure for 5 cycles in the middle of PAD.
        exp_write(W'(5));
        exp_q.push_back(PAD_MSG);
        exp_q.push_back(PAD_MSG);
        exp_q.push_back(PAD_MSG);
        exp_q.push_back(RUN_MSG);
        send_word(W'(5), 1'b1);
        check("pad_msg", 32'(bus.send_msg), 32'(PAD_MSG));
        @(posedge clk);
        #1;
        bus.send_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_send_val", 32'(bus.send_val), 32'd1);
            check("bp_send_msg", 32'(bus.send_msg), 32'(PAD_MSG));
            check("bp_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        check("bp_pending", 32'(exp_q.size()), 32'd3);
        bus.send_rdy = 1'b1;
        drain();
        check("bp_frame_cnt", 32'(frame_cnt), 32'd3);
        check("bp_busy_after", 32'(busy), 32'd0);

        // Run stall for 10 cycles with a new word waiting upstream.
        full_frame(1'b0);
        bus.send_rdy = 1'b0;
        bus.in_val   = 1'b1;
        bus.in_data  = W'(16'h00aa);
        for (int k = 0; k < 10; k++) begin
            check("stall_send_val", 32'(bus.send_val), 32'd1);
            check("stall_send_msg", 32'(bus.send_msg), 32'(RUN_MSG));
            check("stall_in_rdy", 32'(bus.in_rdy), 32'd0);
            check("stall_frame_cnt", 32'(frame_cnt), 32'd3);
            @(posedge clk);
            #1;
        end
        bus.in_val   = 1'b0;
        bus.send_rdy = 1'b1;
        drain();
        check("stall_frame_cnt_after", 32'(frame_cnt), 32'd4);

        // Reset after two words: partial frame discarded.
        exp_write(W'(16'h0011));
        exp_write(W'(16'h0022));
        send_word(W'(16'h0011), 1'b0);
        send_word(W'(16'h0022), 1'b0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset       = 1'b1;
        bus.in_val  = 1'b1;
        bus.in_data = W'(16'h0033);
        #1;
        check("mid_rst_in_rdy", 32'(bus.in_rdy), 32'd0);
        check("mid_rst_send_val", 32'(bus.send_val), 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        bus.in_val = 1'b0;
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        full_frame(1'b0);
        drain();
        check("post_rst_frame", 32'(frame_cnt), 32'd1);

        // Wrap: 255 more frames, some with in_last on the final word (no pads).
        for (int f = 0; f < 254; f++) begin
            full_frame((f % 3) == 0);
        end
        drain();
        check("pre_wrap_frame_cnt", 32'(frame_cnt), 32'd255);
        full_frame(1'b1);
        drain();
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
        check("wrap_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/memory_load_sequencer.md
MEMORY_LOAD_SEQUENCER -- requirements
Module: memory_load_sequencer

Interface
REQ-001 SHALL have parameter DATA_ENTRIES, default 8: entries per frame (power of two, >=2; matches the downstream memory engine depth).
REQ-002 SHALL take the word width W = INT_WIDTH+FRAC_WIDTH from the shared data_type definitions.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_val  input  1  upstream word valid.
REQ-006 SHALL have port in_rdy  output  1  upstream word ready.
REQ-007 SHALL have port in_data  input  W  upstream data word.
REQ-008 SHALL have port in_last  input  1  marks the final word of a short frame; qualified by in_val.
REQ-009 SHALL have port send_val  output  1  message valid toward the memory engine.
REQ-010 SHALL have port send_rdy  input  1  memory engine ready.
REQ-011 SHALL have port send_msg  output  W+2  {data[W-1:0], cmd[1:0]}; cmd 2'b00 = write, 2'b11 = run.
REQ-012 SHALL have port frame_cnt  output  8  number of run messages issued, wrapping modulo 256.
REQ-013 SHALL have port busy  output  1  high when a frame is partly loaded, padding, or awaiting run acceptance.

Function
REQ-014 SHALL implement FSM states LOAD, PAD and RUN, plus an entry counter cnt of width $clog2(DATA_ENTRIES).
REQ-015 SHALL define transfer as send_val && send_rdy (downstream) and in_val && in_rdy (upstream).
REQ-016 In LOAD: send_val = in_val; in_rdy = send_rdy; send_msg = {in_data, 2'b00}; combinational pass-through with zero latency.
REQ-017 In LOAD, on a transfer with cnt == DATA_ENTRIES-1: SHALL go to RUN and clear cnt, regardless of in_last.
REQ-018 In LOAD, on a transfer with in_last = 1 and cnt < DATA_ENTRIES-1: SHALL go to PAD and set cnt to cnt+1.
REQ-019 In LOAD, on any other transfer: SHALL increment cnt and stay in LOAD.
REQ-020 In PAD: in_rdy = 0; send_val = 1; send_msg = {W'b0, 2'b00}. On each transfer cnt increments. The transfer at cnt == DATA_ENTRIES-1 SHALL move to RUN and clear cnt.
REQ-021 In RUN: in_rdy = 0; send_val = 1; send_msg = {W'b0, 2'b11}. On transfer SHALL go to LOAD and increment frame_cnt (255 wraps to 0).
REQ-022 Without a transfer, state, cnt and frame_cnt SHALL hold; send_val, once asserted in PAD or RUN, SHALL remain asserted until transfer.
REQ-023 Every frame SHALL deliver exactly DATA_ENTRIES write messages followed by one run message; words arrive in input order.
REQ-024 A word carrying in_last on entry index DATA_ENTRIES-1 SHALL produce no pad words.
REQ-025 Backpressure: the engine deasserts send_rdy while reading out; the sequencer SHALL stall in place with no lost or duplicated message.
REQ-026 busy SHALL equal (state != LOAD) || (cnt != 0); it is combinational.
REQ-027 send_msg SHALL be {W'b0, 2'b00} whenever send_val = 0.

Reset
REQ-028 While reset is asserted, the block SHALL enter LOAD with cnt = 0 and frame_cnt = 0; in_rdy and send_val SHALL be 0 during the reset cycle.
REQ-029 Reset mid-frame (PAD, RUN or partial LOAD) SHALL discard the partial frame; the first post-reset word is entry 0.

Verification (DATA_ENTRIES=4)
REQ-030 Full frame: words 1,2,3,4 with send_rdy = 1 -> writes 1,2,3,4 with cmd 00 in consecutive cycles, then run 2'b11, frame_cnt = 1, busy = 0 after.
REQ-031 Short frame: words 7,8 with in_last on 8 -> writes 7,8,0,0, then run; in_rdy = 0 for the 3 cycles of pad+run.
REQ-032 Backpressure: send_rdy low for 5 cycles in the middle of PAD -> send_val held at 1, pad message unchanged, no extra pad issued.
REQ-033 Run stall: send_rdy = 0 for 10 cycles in RUN -> run message held; the next frame is not accepted until run transfers.
REQ-034 Reset after 2 words loaded -> busy = 0 and frame_cnt = 0; a following 4-word frame delivers exactly 4 writes and 1 run.
REQ-035 Wrap: 256 back-to-back full frames -> frame_cnt returns to 0; last-on-4th-word cases produce no padding.
